adder_share_sched: RTL

Round-robin scheduler that shares one pipelined 16-bit adder between NREQ requesters. Accepts operand triples (a, b, cin) over per-requester valid/ready handshakes and issues at most one per cycle into the adder. A LAT-deep tag pipeline tracks each in-flight operation so the result can be routed back with its requester ID. A credit-limited response FIFO absorbs back-pressure from the single response port without ever stalling the adder pipeline.

---
 rtl/adder_share_pkg.sv | 27 ++
 rtl/adder_share_rsp_fifo.sv | 101 ++++++++++
 rtl/adder_share_rsp_fifo_chk.sv | 15 +
 rtl/adder_share_sched.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared constants, the response entry layout and a
// ceiling-log2 helper used by the adder-sharing scheduler.
package adder_share_pkg;

  // Operand width of the shared adder
  localparam int OPW     = 16;
  // Widest requester id the response entry can carry (NREQ up to 8)
  localparam int ID_MAXW = 3;

  // One response as it sits in the FIFO
  typedef struct packed {
    logic [OPW-1:0]     sum;
    logic               cout;
    logic [ID_MAXW-1:0] id;
  } rsp_entry_t;

  // Ceiling log2, at least 1 for n >= 2
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_share_rsp_fifo.sv
// adder_share_rsp_fifo: synchronous FIFO whose head entry lives in its own
// register, so the read data never depends combinationally on the write side.
module adder_share_rsp_fifo
  import adder_share_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 20,
  parameter int CW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_nxt_s;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic [CW-1:0] count_r;
  logic [W-1:0]  head_r;
  logic [W-1:0]  head_nxt_s;
  logic          rd_ok_s;
  logic          wr_ok_s;

  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == CW'(0));
  assign count   = count_r;
  assign rd_data = head_r;
  assign rd_ok_s = rd_en && !empty;
  assign wr_ok_s = wr_en && (!full || rd_ok_s);

  // Pointer increments with wrap at DEPTH (DEPTH need not be a power of two)
  always_comb begin
    wr_ptr_nxt_s = (wr_ptr_r == PW'(DEPTH - 1)) ? PW'(0) : wr_ptr_r + PW'(1);
    rd_ptr_nxt_s = (rd_ptr_r == PW'(DEPTH - 1)) ? PW'(0) : rd_ptr_r + PW'(1);
  end

  // Next head: following stored entry, or the incoming write when the FIFO drains to it
  always_comb begin
    head_nxt_s = head_r;
    if (rd_ok_s) begin
      if (count_r > CW'(1)) begin
        head_nxt_s = mem_r[rd_ptr_nxt_s];
      end else if (wr_ok_s) begin
        head_nxt_s = wr_data;
      end else begin
        head_nxt_s = '0;
      end
    end else if (empty && wr_ok_s) begin
      head_nxt_s = wr_data;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Pointers, occupancy and head register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_nxt_s;
      if (rd_ok_s) rd_ptr_r <= rd_ptr_nxt_s;
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      head_r <= head_nxt_s;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  adder_share_rsp_fifo_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .wr_en (wr_en),
    .rd_en (rd_ok_s),
    .full  (full)
  );

endmodule

// File: rtl/adder_share_rsp_fifo_chk.sv
// adder_share_rsp_fifo_chk: overflow checker for the response FIFO.
module adder_share_rsp_fifo_chk (
  input logic clk,
  input logic reset,
  input logic wr_en,
  input logic rd_en,
  input logic full
);

  // A write into a full FIFO without a same-cycle read would lose a result
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(wr_en && full && !rd_en))
    else $error("adder_share_rsp_fifo overflow");

endmodule

// File: rtl/adder_share_sched.sv
// adder_share_sched: shares one LAT-deep pipelined adder between NREQ
// requesters. Results are tagged through a shadow pipeline and parked in a
// credit-protected response FIFO so the adder never has to stall.
// Optional feature macro: ADDER_SHARE_RR_EN selects round-robin arbitration;
// without it the lowest requester index always wins.
module adder_share_sched
  import adder_share_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [OPW*NREQ-1:0]    req_a,
  input  logic [OPW*NREQ-1:0]    req_b,
  input  logic [NREQ-1:0]        req_cin,
  output logic [OPW-1:0]         add_a,
  output logic [OPW-1:0]         add_b,
  output logic                   add_cin,
  input  logic [OPW-1:0]         add_sum,
  input  logic                   add_cout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [OPW-1:0]         rsp_sum,
  output logic                   rsp_cout,
  output logic [clog2(NREQ)-1:0] rsp_id
);

  localparam int IDW = clog2(NREQ);
  localparam int IFW = clog2(LAT + 1);
  localparam int CW  = clog2(FIFO_DEPTH + 1);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("adder_share_sched: NREQ must be 2..8");
  end
  if (LAT < 1 || LAT > 8) begin : g_bad_lat
    $error("adder_share_sched: LAT must be 1..8");
  end
  if (FIFO_DEPTH < LAT + 1) begin : g_bad_depth
    $error("adder_share_sched: FIFO_DEPTH must be at least LAT+1");
  end

  logic [IDW-1:0] gid_s;
  logic [IDW-1:0] idx_s;
  logic           found_s;
  logic           credit_s;
  logic           issue_s;
  logic           retire_s;
  logic           tag_valid_r [LAT];
  logic [IDW-1:0] tag_id_r    [LAT];
  logic [IFW-1:0] inflight_r;
  logic [CW-1:0]  fifo_count_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  rsp_entry_t     wr_entry_s;
  rsp_entry_t     head_s;
  logic           unused_s;

`ifdef ADDER_SHARE_RR_EN
  logic [IDW-1:0] last_grant_r;
`endif

  // Conservative credit: a pop in this same cycle is not counted
  assign credit_s = (int'(inflight_r) + int'(fifo_count_s)) < FIFO_DEPTH;
  assign issue_s  = found_s && credit_s && reset;
  assign retire_s = tag_valid_r[LAT-1];

  // Arbitration: pick the winning requester among those with valid high
  always_comb begin
    gid_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
`ifdef ADDER_SHARE_RR_EN
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = IDW'((int'(last_grant_r) + k) % NREQ);
      if (!found_s && req_valid[idx_s]) begin
        found_s = 1'b1;
        gid_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
`else
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx_s = IDW'(i);
      if (req_valid[idx_s]) begin
        found_s = 1'b1;
        gid_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
`endif
  end

  // Grant and operand steering to the shared adder; zeros when idle
  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    if (issue_s) begin
      req_ready[gid_s] = 1'b1;
      add_a            = req_a[int'(gid_s)*OPW +: OPW];
      add_b            = req_b[int'(gid_s)*OPW +: OPW];
      add_cin          = req_cin[gid_s];
    end else begin
      req_ready = '0;
    end
  end

`ifdef ADDER_SHARE_RR_EN
  // Round-robin pointer moves only on an actual transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_r <= IDW'(NREQ - 1);
    end else if (issue_s) begin
      last_grant_r <= gid_s;
    end
  end
`endif

  // Tag pipeline shadowing the adder latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        tag_valid_r[i] <= 1'b0;
        tag_id_r[i]    <= '0;
      end
    end else begin
      tag_valid_r[0] <= issue_s;
      tag_id_r[0]    <= gid_s;
      for (int i = 1; i < LAT; i++) begin
        tag_valid_r[i] <= tag_valid_r[i-1];
        tag_id_r[i]    <= tag_id_r[i-1];
      end
    end
  end

  // Count of operations inside the adder
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_r <= '0;
    end else begin
      case ({issue_s, retire_s})
        2'b10:   inflight_r <= inflight_r + IFW'(1);
        2'b01:   inflight_r <= inflight_r - IFW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Assemble the retiring result for the FIFO
  always_comb begin
    wr_entry_s      = '0;
    wr_entry_s.sum  = add_sum;
    wr_entry_s.cout = add_cout;
    wr_entry_s.id   = ID_MAXW'(tag_id_r[LAT-1]);
  end

  adder_share_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(rsp_entry_t)),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (retire_s),
    .wr_data (wr_entry_s),
    .rd_en   (rsp_valid && rsp_ready),
    .rd_data (head_s),
    .count   (fifo_count_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign rsp_valid = !fifo_empty_s;
  assign rsp_sum   = head_s.sum;
  assign rsp_cout  = head_s.cout;
  assign rsp_id    = head_s.id[IDW-1:0];

  // Full is implied by credit; upper id bits are spare for small NREQ
  assign unused_s = ^{fifo_full_s, head_s.id};

endmodule
